// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: requester handshake plus shared 4-bit adder hookup for the nibble-serial sequencer.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    modport slave (
        input  start, op_a, op_b, cin, sub, add_sum, add_cout,
        output busy, done, result, cout, overflow, add_a, add_b, add_cin
    );
    modport master (
        output start, op_a, op_b, cin, sub, add_sum, add_cout,
        input  busy, done, result, cout, overflow, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide add/subtract done one nibble per clock, LSB first, through an external 4-bit adder.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = RUN;
                a_d      = bus.op_a;
                // subtraction is A + ~B + 1, so invert B once here and seed the carry
                b_d      = bus.sub ? ~bus.op_b : bus.op_b;
                carry_d  = bus.sub | bus.cin;
                idx_d    = '0;
                result_d = '0;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
            end
            RUN: begin
                result_d[4*idx_q +: 4] = bus.add_sum;
                carry_d = bus.add_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = bus.add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_sum[3] != a_q[W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = state_q == RUN;
    assign bus.done     = state_q == DONE;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.add_a    = bus.busy ? a_q[4*idx_q +: 4] : 4'h0;
    assign bus.add_b    = bus.busy ? b_q[4*idx_q +: 4] : 4'h0;
    assign bus.add_cin  = bus.busy & carry_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed checks against a whole-word arithmetic reference model.
module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // the shared combinational 4-bit adder
    assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input logic [W-1:0] r);
        chk("busy_q", 64'(bus.busy), 64'(0));
        chk("done_q", 64'(bus.done), 64'(0));
        chk("result_q", 64'(bus.result), 64'(r));
        chk("add_a_q", 64'(bus.add_a), 64'(0));
        chk("add_b_q", 64'(bus.add_b), 64'(0));
        chk("add_cin_q", 64'(bus.add_cin), 64'(0));
    endtask

    // inj: cycle index (1..N+1) after acceptance at which a stray start is pulsed, 0 = none
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s, input int inj);
        logic [W-1:0] bb, r;
        logic [W:0]   full, m, low;
        logic         c0, ov;
        bb   = s ? ~b : b;
        c0   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
        r    = full[W-1:0];
        ov   = s ? (a[W-1] != b[W-1]) && (r[W-1] != a[W-1])
                 : (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        bus.sub   = s;
        for (int j = 1; j <= N + 1; j++) begin
            @(negedge clk);
            bus.start = (j == inj);
            if (j == inj) begin
                bus.op_a = W'($urandom);
                bus.op_b = W'($urandom);
                bus.cin  = 1'($urandom);
                bus.sub  = 1'($urandom);
            end
            if (j <= N) begin
                m   = ~({(W+1){1'b1}} << (4 * (j - 1)));
                low = ({1'b0, a} & m) + ({1'b0, bb} & m) + (W+1)'(c0);
                chk("busy", 64'(bus.busy), 64'(1));
                chk("done_early", 64'(bus.done), 64'(0));
                chk("add_a", 64'(bus.add_a), 64'(a[4*(j-1) +: 4]));
                chk("add_b", 64'(bus.add_b), 64'(bb[4*(j-1) +: 4]));
                chk("add_cin", 64'(bus.add_cin), 64'(low[4*(j-1)]));
            end else begin
                chk("done", 64'(bus.done), 64'(1));
                chk("busy_done", 64'(bus.busy), 64'(0));
                chk("result", 64'(bus.result), 64'(r));
                chk("cout", 64'(bus.cout), 64'(full[W]));
                chk("overflow", 64'(bus.overflow), 64'(ov));
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_quiet('0);
        chk("cout_rst", 64'(bus.cout), 64'(0));
        chk("ovf_rst", 64'(bus.overflow), 64'(0));

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        run_op(16'h8888, 16'h8888, 1'b0, 1'b0, 0);
        run_op(16'hDDDD, 16'hBBBB, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("hold_result", 64'(bus.result), 64'(16'h8000));
        chk("hold_cout", 64'(bus.cout), 64'(0));
        chk("hold_ovf", 64'(bus.overflow), 64'(1));
        chk("hold_done", 64'(bus.done), 64'(0));
        run_op(16'h1234, 16'h1235, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 2);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, N + 1);
        run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h4321;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_quiet('0);
        run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 0);

        for (int t = 0; t < 40; t++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, N + 1)));

        @(negedge clk);
        bus.start = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that reuses one external 4-bit parallel adder to add or subtract two wide operands, one nibble per clock, LSB nibble first.
- Latches operands on a start pulse, drives the adder operands and carry-in each cycle, and collects sum nibbles into a result register.
- Registers the final carry and the signed overflow, then signals completion with a one-cycle done pulse.
- Sits between a requesting unit and the shared 4-bit adder instance; the adder itself stays combinational and outside this block.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op_a  input  W  operand A; sampled when start is accepted
- op_b  input  W  operand B; sampled when start is accepted
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1 = compute A-B, 0 = compute A+B+cin; sampled when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- result  output  W  registered sum or difference; held until the next accepted start
- cout  output  1  final carry-out; for sub, 1 = no borrow
- overflow  output  1  two's-complement signed overflow of the W-bit operation
- add_a  output  4  to adder input a
- add_b  output  4  to adder input b
- add_cin  output  1  to adder input cin
- add_sum  input  4  from adder output sum
- add_cout  input  1  from adder output cout

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, cout, overflow = 0; result = 0; internal index and carry = 0. Reset has priority over every other event, including mid-RUN; the aborted operation is discarded.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while idx < NIBBLES-1.
  - RUN -> DONE after the slice with idx = NIBBLES-1 is captured.
  - DONE -> IDLE unconditionally after one cycle.
- Accepting start in IDLE:
  - a_reg <= op_a.
  - b_reg <= sub ? ~op_b : op_b.
  - carry <= sub ? 1 : cin.
  - idx <= 0.
  - result <= 0.
  - cout and overflow <= 0.
- start in RUN or DONE is ignored and not queued.
- Adder drive, combinational from registers:
  - In RUN: add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_cin = carry.
  - Outside RUN: all three are 0.
- Each RUN edge:
  - result[4*idx+3:4*idx] <= add_sum.
  - carry <= add_cout.
  - idx <= idx+1.
- Last RUN edge (idx = NIBBLES-1):
  - cout <= add_cout.
  - overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]).
- DONE: done=1 for exactly that cycle; busy=0. result, cout and overflow are valid from this cycle and are held through IDLE.
- Latency: with start sampled at edge k, busy is high for edges k+1..k+NIBBLES. done is high in the cycle after edge k+NIBBLES, i.e. NIBBLES+1 cycles from start to done. The next start is accepted no earlier than the cycle after done.
- Widths: all arithmetic is modulo 2^W; the carry chain runs only through the carry register. No combinational path exists from add_sum/add_cout to any block output.

Test Plan:
- NIBBLES=4, op_a=0x0000, op_b=0x0000, cin=0, sub=0 -> result 0x0000, cout 0, overflow 0; busy high 4 cycles; done pulses exactly 5 cycles after start.
- op_a=0x8888, op_b=0x8888, cin=0 -> result 0x1110, cout 1, overflow 1. Monitor per cycle that add_a/add_b = 0x8 and add_cin goes 0,1,1,1.
- op_a=0xDDDD, op_b=0xBBBB, cin=1 -> result 0x9999, cout 1, overflow 0. Also op_a=0x7FFF, op_b=0x0001 -> result 0x8000, cout 0, overflow 1.
- sub=1, op_a=0x1234, op_b=0x1235, cin=1 (ignored) -> result 0xFFFF, cout 0, overflow 0. Also sub=1, op_a=0x8000, op_b=0x0001 -> result 0x7FFF, cout 1, overflow 1.
- Pulse start with new operands during RUN and during DONE -> ignored; the first operation's result is unchanged; a start pulsed in the cycle after done is accepted.
- Assert rst for one cycle at the third RUN cycle -> next cycle busy=0, done=0, result=0x0000, add_a/add_b/add_cin=0. A subsequent start with 0x0FFF+0x0001 completes normally: result 0x1000, cout 0.
